// File: rtl/otter_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// Op codes mirror FUNCT3; latency counts from the START cycle to the DONE cycle.
package otter_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } muldiv_state_t;

    localparam logic [31:0] MULDIV_DIV0_Q  = 32'hFFFF_FFFF;
    localparam int          MULDIV_LATENCY = 34;

endpackage

// File: rtl/otter_muldiv_unit_if.sv
// EX-stage request/response bundle between hazard logic and the mul/div unit.
// Latency: fixed, set by the unit (START cycle to DONE cycle).
// Backpressure: none; the requester holds off while BUSY is high, START is dropped otherwise.
interface otter_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            START;
    logic            FLUSH;
    logic [2:0]      FUNCT3;
    logic [XLEN-1:0] SRC_A;
    logic [XLEN-1:0] SRC_B;
    logic            BUSY;
    logic            DONE;
    logic [XLEN-1:0] RESULT;

    modport master (
        output START, FLUSH, FUNCT3, SRC_A, SRC_B,
        input  BUSY, DONE, RESULT
    );

    modport slave (
        input  START, FLUSH, FUNCT3, SRC_A, SRC_B,
        output BUSY, DONE, RESULT
    );
endinterface

// File: rtl/otter_muldiv_unit.sv
// Iterative RV32M multiply (shift-add) / divide (restoring) unit on magnitudes with sign fix-up.
// Latency: fixed, ITERS+2 cycles after acceptance (34 from the START cycle to DONE).
// Backpressure: START accepted only in IDLE; anything else is ignored, FLUSH aborts without DONE.
module otter_muldiv_unit
    import otter_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ITERS = XLEN
) (
    input  logic CLK,
    input  logic RST,
    otter_muldiv_unit_if.slave bus
);

    localparam int CW = 6;

    muldiv_state_t     state, state_nxt;
    muldiv_op_t        op, op_in;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   sr, opnd, result;
    logic              neg_res, div0;

    logic              a_sgn, b_sgn, a_neg, b_neg, accept;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
    logic [XLEN-1:0]   rem_nxt;
    logic              q_bit;
    logic [2*XLEN-1:0] fix_abs, fix_val;
    logic [XLEN-1:0]   fix_res;

    function automatic logic [XLEN-1:0] neg_op(input logic n, input logic [XLEN-1:0] v);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_wide(input logic n, input logic [2*XLEN-1:0] v);
        return n ? (~v + 1'b1) : v;
    endfunction

    // Operand signedness and magnitudes for an incoming request
    always_comb begin
        op_in = muldiv_op_t'(bus.FUNCT3);
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (op_in)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            OP_MULHSU: a_sgn = 1'b1;
            default: ;
        endcase
        a_neg  = a_sgn & bus.SRC_A[XLEN-1];
        b_neg  = b_sgn & bus.SRC_B[XLEN-1];
        abs_a  = neg_op(a_neg, bus.SRC_A);
        abs_b  = neg_op(b_neg, bus.SRC_B);
        accept = (state == ST_IDLE) && bus.START && !bus.FLUSH;
    end

    // One iteration: multiplier LSB gates an add into the high half; dividend MSB shifts into remainder
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (sr[0] ? opnd : {XLEN{1'b0}})};
        rem_sh   = {acc[XLEN-1:0], sr[XLEN-1]};
        rem_diff = rem_sh - {1'b0, opnd};
        q_bit    = ~rem_diff[XLEN];
        rem_nxt  = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    end

    always_comb begin
        fix_abs = op[2] ? {{XLEN{1'b0}}, (op[1] ? acc[XLEN-1:0] : sr)} : acc;
        fix_val = neg_wide(neg_res, fix_abs);
        case (op)
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = fix_val[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             fix_res = div0 ? MULDIV_DIV0_Q : fix_val[XLEN-1:0];
            default:                     fix_res = fix_val[XLEN-1:0];
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_RUN;
            ST_RUN: begin
                if (bus.FLUSH)                   state_nxt = ST_IDLE;
                else if (cnt == CW'(ITERS - 1))  state_nxt = ST_FIX;
            end
            ST_FIX:  state_nxt = bus.FLUSH ? ST_IDLE : ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.BUSY = (state != ST_IDLE);
        bus.DONE = (state == ST_DONE);
    end

    assign bus.RESULT = result;

    always_ff @(posedge CLK) begin
        if (RST) begin
            op      <= OP_MUL;
            cnt     <= '0;
            acc     <= '0;
            sr      <= '0;
            opnd    <= '0;
            neg_res <= 1'b0;
            div0    <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    op      <= op_in;
                    cnt     <= '0;
                    acc     <= '0;
                    opnd    <= op_in[2] ? abs_b : abs_a;
                    sr      <= op_in[2] ? abs_a : abs_b;
                    neg_res <= (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
                    div0    <= (bus.SRC_B == '0);
                end
                ST_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (op[2]) begin
                        acc <= {{XLEN{1'b0}}, rem_nxt};
                        sr  <= {sr[XLEN-2:0], q_bit};
                    end else begin
                        acc <= {mul_sum, acc[XLEN-1:1]};
                        sr  <= sr >> 1;
                    end
                end
                ST_FIX: if (!bus.FLUSH) result <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_otter_muldiv_unit.sv
// Randomized scoreboard bench for otter_muldiv_unit against an arithmetic RV32M reference.
module tb_otter_muldiv_unit;
    import otter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    otter_muldiv_unit_if #(.XLEN(32)) bus();

    otter_muldiv_unit #(.XLEN(32), .ITERS(32)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] res;
        int          done_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          busy_run = 0;
    logic [31:0] last_res = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'(signed'(a));
        longint      sb = longint'(signed'(b));
        longint      ub = longint'({32'd0, b});
        logic [63:0] p;
        logic [31:0] r;
        case (f3)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0];  end
            3'd1: begin p = sa * sb;                 r = p[63:32]; end
            3'd2: begin p = sa * ub;                 r = p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_opnd();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = $urandom_range(0, 15);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: every DONE must match the oldest outstanding request
    always @(negedge clk) begin
        exp_t e;
        if (bus.BUSY) busy_run++;
        else          busy_run = 0;
        if (bus.DONE) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: DONE high with result %h, no request outstanding (cycle %0d)", bus.RESULT, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("result", bus.RESULT, e.res);
                chk("done_cycle", cyc, e.done_cyc);
                chk("busy_cycles", busy_run, MULDIV_LATENCY);
            end
        end
    end

    // Called #1 after a rising edge; leaves control #1 after the accepting edge
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit expect_done);
        exp_t e;
        bus.START  = 1'b1;
        bus.FUNCT3 = f3;
        bus.SRC_A  = a;
        bus.SRC_B  = b;
        if (expect_done) begin
            e.res      = ref_model(f3, a, b);
            e.done_cyc = cyc + MULDIV_LATENCY;
            exp_q.push_back(e);
            last_res   = e.res;
        end
        @(posedge clk); #1;
        bus.START  = 1'b0;
        bus.FUNCT3 = 3'($urandom);
        bus.SRC_A  = $urandom;
        bus.SRC_B  = $urandom;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 80) begin
            @(posedge clk); #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: %0d result(s) still outstanding after %0d cycles", exp_q.size(), k);
            exp_q.delete();
        end
    endtask

    task automatic flush_at(input int run_cycle);
        repeat (run_cycle - 1) @(posedge clk);
        #1;
        bus.FLUSH = 1'b1;
        @(posedge clk); #1;
        bus.FLUSH = 1'b0;
        chk("flush_busy", 32'(bus.BUSY), 32'd0);
        chk("flush_result", bus.RESULT, last_res);
    endtask

    logic [2:0]  d_f3 [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                               32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        bus.START  = 1'b0;
        bus.FLUSH  = 1'b0;
        bus.FUNCT3 = 3'd0;
        bus.SRC_A  = 32'd0;
        bus.SRC_B  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(bus.BUSY), 32'd0);
        chk("reset_done", 32'(bus.DONE), 32'd0);
        chk("reset_result", bus.RESULT, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            issue(d_f3[i], d_a[i], d_b[i], 1'b1);
            wait_drain();
        end

        // A second START mid-RUN must not restart or queue
        issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        bus.START  = 1'b1;
        bus.FUNCT3 = 3'd0;
        bus.SRC_A  = 32'd3;
        bus.SRC_B  = 32'd4;
        @(posedge clk); #1;
        bus.START  = 1'b0;
        chk("mid_start_busy", 32'(bus.BUSY), 32'd1);
        wait_drain();

        // Flush in the 10th RUN cycle, then an immediate new request
        issue(3'd4, 32'hDEAD_BEEF, 32'd13, 1'b0);
        flush_at(10);
        issue(3'd6, 32'hDEAD_BEEF, 32'd13, 1'b1);
        wait_drain();

        // FLUSH wins over START in IDLE
        bus.START = 1'b1;
        bus.FLUSH = 1'b1;
        @(posedge clk); #1;
        bus.START = 1'b0;
        bus.FLUSH = 1'b0;
        chk("flush_start_idle_busy", 32'(bus.BUSY), 32'd0);
        repeat (40) @(posedge clk);
        #1;

        // Reset mid-RUN, and no acceptance while reset is high
        issue(3'd0, 32'd11, 32'd13, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_done", 32'(bus.DONE), 32'd0);
        chk("rst_result", bus.RESULT, 32'd0);
        bus.START  = 1'b1;
        bus.FUNCT3 = 3'd5;
        bus.SRC_A  = 32'd9;
        bus.SRC_B  = 32'd2;
        @(posedge clk); #1;
        bus.START = 1'b0;
        rst       = 1'b0;
        last_res  = 32'd0;
        chk("rst_start_busy", 32'(bus.BUSY), 32'd0);
        @(posedge clk); #1;
        chk("rst_after_busy", 32'(bus.BUSY), 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = rand_opnd();
            b  = rand_opnd();
            if ($urandom_range(0, 7) == 0) begin
                issue(f3, a, b, 1'b0);
                flush_at($urandom_range(1, 33));
            end else begin
                issue(f3, a, b, 1'b1);
                wait_drain();
            end
        end

        repeat (40) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
